// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one execute-stage ALU between two requesters
// Holds the result until the owning requester accepts it; one operation in flight at a time.

`ifndef WORD
`define WORD 64
`endif
`ifndef ALU_AND
`define ALU_AND 4'b0000
`endif
`ifndef ALU_ORR
`define ALU_ORR 4'b0001
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0010
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0110
`endif
`ifndef ALU_CBZ
`define ALU_CBZ 4'b0111
`endif

module alu_arbiter #(
  parameter int WIDTH = `WORD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic [WIDTH-1:0] resp0_result,
  output logic             resp0_zero,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp1_result,
  output logic             resp1_zero
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state;
  state_t           next_state;
  logic             owner;
  logic             prio;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic [WIDTH-1:0] alu_out;
  logic             winner;
  logic             accept;
  logic             resp_done;

  // A lone valid port wins outright; the pointer only breaks ties.
  assign winner    = (req0_valid && req1_valid) ? prio : req1_valid;
  assign accept    = (state == IDLE) && (req0_valid || req1_valid);
  assign resp_done = (state == RESP) && (owner ? resp1_ready : resp0_ready);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    next_state = RESP;
      RESP:    if (resp_done) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    if (state == IDLE) begin
      req0_ready = req0_valid && !winner;
      req1_ready = req1_valid && winner;
    end
    if (state == RESP) begin
      resp0_valid = !owner;
      resp1_valid = owner;
    end
  end

  always_comb begin
    alu_out = a_q & b_q;
    case (op_q)
      `ALU_ADD: alu_out = a_q + b_q;
      `ALU_SUB: alu_out = a_q - b_q;
      `ALU_AND: alu_out = a_q & b_q;
      `ALU_ORR: alu_out = a_q | b_q;
      `ALU_CBZ: alu_out = b_q;
      default:  alu_out = a_q & b_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= 1'b0;
      prio     <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      if (accept) begin
        owner <= winner;
        op_q  <= winner ? req1_op : req0_op;
        a_q   <= winner ? req1_a : req0_a;
        b_q   <= winner ? req1_b : req0_b;
      end
      if (state == EXEC) begin
        result_q <= alu_out;
        zero_q   <= (alu_out == '0);
      end
      if (resp_done) prio <= ~owner;
    end
  end

  assign resp0_result = result_q;
  assign resp1_result = result_q;
  assign resp0_zero   = zero_q;
  assign resp1_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.

`ifndef WORD
`define WORD 64
`endif
`ifndef ALU_AND
`define ALU_AND 4'b0000
`endif
`ifndef ALU_ORR
`define ALU_ORR 4'b0001
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'b0010
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0110
`endif
`ifndef ALU_CBZ
`define ALU_CBZ 4'b0111
`endif

module tb_alu_arbiter;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0_valid, req0_ready, resp0_valid, resp0_ready, resp0_zero;
  logic         req1_valid, req1_ready, resp1_valid, resp1_ready, resp1_zero;
  logic [3:0]   req0_op, req1_op;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b, resp0_result, resp1_result;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_result(resp0_result), .resp0_zero(resp0_zero),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_result(resp1_result), .resp1_zero(resp1_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int port, input logic v, input logic [3:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    if (port == 0) begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end
  endtask

  // One complete operation on a single port with resp ready high; called at edge+1.
  task automatic run_op(input int port, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_r, input logic exp_z);
    logic got;
    got = 1'b0;
    set_req(port, 1'b1, op, a, b);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    check("op_accept", {63'd0, got}, 64'd1);
    tick();
    set_req(port, 1'b0, op, a, b);
    @(negedge clk);
    check("op_exec_no_resp", {62'd0, resp1_valid, resp0_valid}, 64'd0);
    tick();
    @(negedge clk);
    check("op_resp_port", {62'd0, resp1_valid, resp0_valid}, (port == 0) ? 64'd1 : 64'd2);
    check("op_result", (port == 0) ? resp0_result : resp1_result, exp_r);
    check("op_zero", {63'd0, (port == 0) ? resp0_zero : resp1_zero}, {63'd0, exp_z});
    tick();
  endtask

  initial begin
    logic [W-1:0] exp_last;
    logic         last_owner, p;
    int           ng, nr, cnt0, cnt1, last_cyc;

    reset = 1'b1;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    set_req(0, 1'b0, `ALU_AND, '0, '0);
    set_req(1, 1'b0, `ALU_AND, '0, '0);
    tick(); tick();
    @(negedge clk);
    check("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
    check("rst_resp_valid", {62'd0, resp1_valid, resp0_valid}, 64'd0);
    check("rst_result", resp0_result, 64'd0);
    check("rst_zero", {63'd0, resp0_zero}, 64'd1);
    tick();
    reset = 1'b0;

    // Single add, sub to zero and wrap-around
    run_op(0, `ALU_ADD, 64'd5, 64'd7, 64'd12, 1'b0);
    run_op(1, `ALU_SUB, 64'd9, 64'd9, 64'd0, 1'b1);
    run_op(1, `ALU_SUB, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Contention: four orr ops per port, expect strict alternation 3 cycles apart
    cnt0 = 0; cnt1 = 0; ng = 0; nr = 0; last_cyc = 0;
    last_owner = 1'b0; exp_last = '0;
    set_req(0, 1'b1, `ALU_ORR, 64'd1, 64'h100);
    set_req(1, 1'b1, `ALU_ORR, 64'h10, 64'h1000);
    for (int cyc = 0; cyc < 60; cyc++) begin
      logic acc;
      acc = 1'b0;
      p = 1'b0;
      @(negedge clk);
      if (resp0_valid || resp1_valid) begin
        check("cont_resp_port", {62'd0, resp1_valid, resp0_valid}, last_owner ? 64'd2 : 64'd1);
        check("cont_result", resp0_result, exp_last);
        nr++;
      end
      if (req0_ready || req1_ready) begin
        acc = 1'b1;
        p = req1_ready;
        check("cont_order", {63'd0, p}, ng % 2);
        if (ng > 0) check("cont_gap", cyc - last_cyc, 64'd3);
        last_cyc = cyc;
        last_owner = p;
        exp_last = p ? (req1_a | req1_b) : (req0_a | req0_b);
        ng++;
      end
      tick();
      if (acc && !p) begin
        cnt0++;
        if (cnt0 == 4) req0_valid = 1'b0;
        else req0_a = W'(cnt0 + 1);
      end
      if (acc && p) begin
        cnt1++;
        if (cnt1 == 4) req1_valid = 1'b0;
        else req1_a = W'((cnt1 + 1) << 4);
      end
      if (nr == 8) break;
    end
    check("cont_grants", ng, 64'd8);
    check("cont_resps", nr, 64'd8);

    // Backpressure on port 0 while port 1 waits
    resp0_ready = 1'b0;
    set_req(0, 1'b1, `ALU_AND, 64'hF0, 64'h3C);
    set_req(1, 1'b1, `ALU_ADD, 64'd1, 64'd1);
    @(negedge clk);
    check("bp_accept0", {62'd0, req1_ready, req0_ready}, 64'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {62'd0, resp1_valid, resp0_valid}, 64'd1);
      check("bp_hold_result", resp0_result, 64'h30);
      check("bp_req1_blocked", {63'd0, req1_ready}, 64'd0);
      tick();
    end
    resp0_ready = 1'b1;
    @(negedge clk);
    check("bp_release_blocked", {63'd0, req1_ready}, 64'd0);
    tick();
    @(negedge clk);
    check("bp_accept1", {63'd0, req1_ready}, 64'd1);
    tick();
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    check("bp_resp1", {62'd0, resp1_valid, resp0_valid}, 64'd2);
    check("bp_result1", resp1_result, 64'd2);
    tick();

    // Reset during EXEC; pointer is 1 beforehand so the tie after reset must go to port 0
    run_op(0, `ALU_AND, 64'hFF, 64'h0F, 64'h0F, 1'b0);
    set_req(0, 1'b1, `ALU_ADD, 64'd1, 64'd2);
    @(negedge clk);
    check("rst_mid_accept", {63'd0, req0_ready}, 64'd1);
    tick();
    req0_valid = 1'b0;
    reset = 1'b1;
    tick();
    @(negedge clk);
    check("rst_mid_resp", {62'd0, resp1_valid, resp0_valid}, 64'd0);
    check("rst_mid_result", resp0_result, 64'd0);
    check("rst_mid_zero", {63'd0, resp0_zero}, 64'd1);
    tick();
    reset = 1'b0;
    set_req(0, 1'b1, `ALU_ADD, 64'd4, 64'd4);
    set_req(1, 1'b1, `ALU_ADD, 64'd8, 64'd8);
    @(negedge clk);
    check("rst_mid_no_resp", {62'd0, resp1_valid, resp0_valid}, 64'd0);
    check("rst_mid_tie", {62'd0, req1_ready, req0_ready}, 64'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    @(negedge clk);
    check("rst_mid_after", resp0_result, 64'd8);
    tick();

    // cbz and an undefined op code
    run_op(0, `ALU_CBZ, 64'd3, 64'd0, 64'd0, 1'b1);
    run_op(1, 4'hF, 64'h6, 64'h3, 64'h2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
